mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch side and the data (MEM stage) side of the 5-stage MIPS core. Grants one requester at a time and sequences the address and data phases of each bus transaction. Routes read data and handshakes back to the owner. Allows the CPU top to move from split instruction/data SRAM to a single unified bus interface.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced to win (used only with FAIR_ARB_EN).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted by bus
inst_data_ok  out  1  fetch read data valid
inst_rdata  out  32  fetch read data
data_req  in  1  data request; held with fields until data_addr_ok
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  byte enables (selM-style)
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted by bus
data_data_ok  out  1  data read done / write ack
data_rdata  out  32  data read data
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_wstrb  out  4  bus byte enables (4'b1111 for fetch)
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_addr_ok  in  1  slave accepted address phase
bus_data_ok  in  1  slave data phase done
bus_rdata  in  32  slave read data
busy  out  1  transaction in flight (state != IDLE)
owner  out  1  current grant: 0 = fetch, 1 = data

Behaviour:
- Reset: asynchronous, active-high. State = IDLE. All outputs 0, including the registered bus_* fields, owner and busy. Any in-flight transaction is dropped, and the slave is reset together with the arbiter.
- States: IDLE, ADDR, DATA. Only one transaction is outstanding at a time.
- Grant point: in IDLE, or in DATA on the cycle bus_data_ok = 1.
  - If any req is pending, latch owner and the owner's fields into the bus_* registers, then go to ADDR.
  - Otherwise go to (or stay in) IDLE.
- Priority: data_req wins over inst_req when both are pending, because the data access belongs to the older instruction.
- Fetch field mapping: bus_wr = 0, bus_wstrb = 4'b1111, bus_wdata = 0.
- ADDR: bus_req = 1 with the latched fields.
  - On bus_addr_ok, pulse the owner's *_addr_ok in the same cycle (combinational) and go to DATA.
  - Otherwise hold all bus_* fields stable.
- DATA: bus_req = 0.
  - On bus_data_ok, drive the owner's *_data_ok = 1 and *_rdata = bus_rdata combinationally in the same cycle.
  - The non-owner sees data_ok = 0 and rdata = 0.
- Minimum latency: req seen in IDLE at cycle t → bus_req at t+1 → addr_ok at t+1 → data_ok at t+2 at the earliest.
- Back-to-back: a new grant on the data_ok cycle gives bus_req on the next cycle, with no idle bubble.
- Requester drops req before its addr_ok after being granted: the transaction still completes from the latched fields, and *_addr_ok/*_data_ok are still delivered.
- bus_addr_ok outside ADDR and bus_data_ok outside DATA are ignored.
- A write completes like a read; data_data_ok is the write acknowledge and data_rdata is don't-care (driven from bus_rdata).

Optional Feature:
FAIR_ARB_EN
- Defined:
  - A starve counter, width clog2(STARVE_LIMIT+1), increments on each data grant made while inst_req = 1.
  - When the counter equals STARVE_LIMIT and both requests are pending, fetch wins the next grant.
  - The counter clears on any fetch grant and on rst.
- Not defined: strict data priority; no counter logic is synthesized.

Test Plan:
- Single fetch: inst_req = 1, addr 0xBFC00000; slave gives addr_ok immediately and data_ok one cycle later with 0x3C010001 → bus_req cycle t+1, inst_addr_ok at t+1, inst_data_ok with inst_rdata = 0x3C010001 at t+2, data_* outputs stay 0.
- Simultaneous requests: inst_req and data_req (read 0x80000010) both set in IDLE → data granted first (owner = 1), fetch granted on the data_data_ok cycle, bus_req for fetch on the next cycle with no idle cycle.
- Write strobes: data_wr = 1, wstrb 4'b0100, wdata 0x00AB0000, addr 0x80000004 → bus_wr = 1, bus_wstrb = 4'b0100 held stable across 3 cycles of bus_addr_ok = 0; data_addr_ok only on the accept cycle.
- Reset mid-transaction: rst asserted while in DATA → same-cycle (asynchronous) bus_req = 0, busy = 0, owner = 0. A later bus_data_ok after release produces no inst/data data_ok.
- Stray handshakes: bus_data_ok = 1 in IDLE and bus_addr_ok = 1 in DATA → no *_ok pulses, state unchanged.
- FAIR_ARB_EN, STARVE_LIMIT = 4: data_req and inst_req held continuously → grant order D,D,D,D,I,D,D,D,D,I. Without the macro → D forever while data_req stays high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like bus port between instruction fetch and the MEM-stage data side.
// Latency: request seen in IDLE at edge t -> bus_req from t; *_addr_ok/*_data_ok/*_rdata are combinational off the bus.
// Backpressure: one transaction in flight; requesters hold req+fields until *_addr_ok; slave stalls via bus_addr_ok/bus_data_ok.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   inst_req/inst_addr             fetch request (read only, full-word)
//   inst_addr_ok/data_ok/rdata     fetch handshakes and read data
//   data_req/wr/wstrb/addr/wdata   MEM-stage request
//   data_addr_ok/data_ok/rdata     data handshakes and read data (write ack on data_ok)
//   bus_req/wr/wstrb/addr/wdata    registered master-side bus fields
//   bus_addr_ok/data_ok/rdata      slave handshakes and read data
//   busy                           a transaction is in flight
//   owner                          current/last grant: 0 = fetch, 1 = data
//
// Optional feature: define FAIR_ARB_EN to enable the anti-starvation counter
// (fetch is forced to win after STARVE_LIMIT consecutive data grants while it waits).

module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,

  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state;
  logic        ownerQ;
  logic        busReqQ;
  logic        busyQ;
  logic        busWrQ;
  logic [3:0]  busWstrbQ;
  logic [31:0] busAddrQ;
  logic [31:0] busWdataQ;

  logic        forceFetch;
  logic        grantPt;
  logic        anyReq;
  logic        pickData;
  logic        addrAccept;
  logic        dataDone;

  // A new grant may be made when idle, or on the very cycle the current
  // transaction finishes, so back-to-back transactions have no bubble.
  assign grantPt    = (state == IDLE) || ((state == DATA) && bus_data_ok);
  assign anyReq     = inst_req | data_req;
  // Data normally wins: it belongs to the older instruction in the pipe.
  assign pickData   = data_req & ~forceFetch;
  // Handshakes from the slave only count in the phase they belong to.
  assign addrAccept = (state == ADDR) && bus_addr_ok;
  assign dataDone   = (state == DATA) && bus_data_ok;

`ifdef FAIR_ARB_EN
  localparam int CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starveCnt;

  assign forceFetch = inst_req & data_req & (starveCnt == CntW'(STARVE_LIMIT));

  // Counts data grants made while fetch was waiting; any fetch grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (grantPt && anyReq) begin
      if (!pickData) begin
        starveCnt <= '0;
      end else if (inst_req && (starveCnt != CntW'(STARVE_LIMIT))) begin
        starveCnt <= starveCnt + CntW'(1);
      end
    end
  end
`else
  // Strict data priority: the fetch override is constant 0.
  assign forceFetch = (STARVE_LIMIT < 0);
`endif

  // Single FSM: state plus every registered bus field and status output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ownerQ    <= 1'b0;
      busReqQ   <= 1'b0;
      busyQ     <= 1'b0;
      busWrQ    <= 1'b0;
      busWstrbQ <= 4'b0000;
      busAddrQ  <= 32'h0;
      busWdataQ <= 32'h0;
    end else begin
      case (state)
        IDLE, DATA: begin
          if (grantPt) begin
            if (anyReq) begin
              state   <= ADDR;
              busReqQ <= 1'b1;
              busyQ   <= 1'b1;
              ownerQ  <= pickData;
              if (pickData) begin
                busWrQ    <= data_wr;
                busWstrbQ <= data_wstrb;
                busAddrQ  <= data_addr;
                busWdataQ <= data_wdata;
              end else begin
                // Fetch is always a full-word read.
                busWrQ    <= 1'b0;
                busWstrbQ <= 4'b1111;
                busAddrQ  <= inst_addr;
                busWdataQ <= 32'h0;
              end
            end else begin
              state   <= IDLE;
              busReqQ <= 1'b0;
              busyQ   <= 1'b0;
            end
          end
        end
        ADDR: begin
          // Fields stay frozen until the slave takes the address phase.
          if (bus_addr_ok) begin
            state   <= DATA;
            busReqQ <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          busReqQ <= 1'b0;
          busyQ   <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req   = busReqQ;
  assign bus_wr    = busWrQ;
  assign bus_wstrb = busWstrbQ;
  assign bus_addr  = busAddrQ;
  assign bus_wdata = busWdataQ;
  assign busy      = busyQ;
  assign owner     = ownerQ;

  // Route handshakes and read data to the owner only; the other side sees zeros.
  assign inst_addr_ok = addrAccept & ~ownerQ;
  assign data_addr_ok = addrAccept &  ownerQ;
  assign inst_data_ok = dataDone   & ~ownerQ;
  assign data_data_ok = dataDone   &  ownerQ;
  assign inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? bus_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        busy, owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .busy(busy), .owner(owner)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  // One record describes the transaction currently on the bus (if any);
  // the last granted fields persist on the bus after it completes.
  typedef struct {
    bit          live;      // a transaction exists
    bit          accepted;  // its address phase has been taken by the slave
    bit          isData;    // granted requester
    bit          wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t cur;
  int   starve;

  function automatic void mReset();
    cur    = '{live: 1'b0, accepted: 1'b0, isData: 1'b0, wr: 1'b0,
               strb: 4'h0, addr: 32'h0, wdata: 32'h0};
    starve = 0;
  endfunction

  function automatic bit dataWins();
`ifdef FAIR_ARB_EN
    return data_req && !(inst_req && starve >= STARVE_LIMIT);
`else
    return data_req;
`endif
  endfunction

  function automatic void mAdvance();
    bit finishing, winsData;
    finishing = cur.live && cur.accepted && bus_data_ok;
    if (!cur.live || finishing) begin
      if (inst_req || data_req) begin
        winsData = dataWins();
        if (winsData) begin
          cur = '{live: 1'b1, accepted: 1'b0, isData: 1'b1, wr: data_wr,
                  strb: data_wstrb, addr: data_addr, wdata: data_wdata};
          if (inst_req) starve++;
        end else begin
          cur = '{live: 1'b1, accepted: 1'b0, isData: 1'b0, wr: 1'b0,
                  strb: 4'hF, addr: inst_addr, wdata: 32'h0};
          starve = 0;
        end
      end else begin
        cur.live = 1'b0;
      end
    end else if (cur.live && !cur.accepted && bus_addr_ok) begin
      cur.accepted = 1'b1;
    end
  endfunction

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin : compare
    logic [11:0] actCtl, expCtl;
    logic [63:0] actRd, expRd;
    bit aOk, dOk;
    mReset();
    forever begin
      @(negedge clk);
      if (rst) mReset();
      aOk = cur.live && !cur.accepted && bus_addr_ok;
      dOk = cur.live &&  cur.accepted && bus_data_ok;
      expCtl = {aOk && !cur.isData, dOk && !cur.isData, aOk && cur.isData, dOk && cur.isData,
                cur.live && !cur.accepted, cur.wr, cur.strb, cur.live, cur.isData};
      actCtl = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                bus_req, bus_wr, bus_wstrb, busy, owner};
      expRd = {(dOk && !cur.isData) ? bus_rdata : 32'h0, (dOk && cur.isData) ? bus_rdata : 32'h0};
      actRd = {inst_rdata, data_rdata};
      check("cyc_ctl", actCtl, expCtl);
      check("cyc_fields", {bus_addr, bus_wdata}, {cur.addr, cur.wdata});
      check("cyc_rdata", actRd, expRd);
      @(posedge clk);
      if (rst) mReset();
      else mAdvance();
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  bit expOrd [10];
  bit gotOrd [10];
  int nGrants;

  initial begin : stim
    #1 rst = 1'b1;
    #2;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_busy_owner", {busy, owner}, 2'b00);
    check("rst_bus_fields", {bus_wr, bus_wstrb, bus_addr, bus_wdata}, '0);
    repeat (2) step();
    rst = 1'b0;

    // Single fetch, minimum latency
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    step();
    bus_addr_ok = 1'b1;
    settle();
    check("t1_bus_req", bus_req, 1'b1);
    check("t1_inst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
    check("t1_bus_fields", {bus_wr, bus_wstrb, bus_addr}, {1'b0, 4'hF, 32'hBFC0_0000});
    step();
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C01_0001;
    settle();
    check("t1_inst_data_ok", inst_data_ok, 1'b1);
    check("t1_inst_rdata", inst_rdata, 32'h3C01_0001);
    check("t1_data_side_zero", {data_data_ok, data_rdata}, 33'h0);
    step();
    bus_data_ok = 1'b0;
    settle();
    check("t1_idle", busy, 1'b0);

    // Simultaneous requests: data first, then fetch with no bubble
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h8000_0010;
    step();
    bus_addr_ok = 1'b1;
    settle();
    check("t2_owner_data", owner, 1'b1);
    check("t2_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
    check("t2_bus_addr", bus_addr, 32'h8000_0010);
    step();
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
    settle();
    check("t2_data_data_ok", {data_data_ok, data_rdata}, {1'b1, 32'h1111_2222});
    step();
    bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
    settle();
    check("t2_fetch_no_bubble", {bus_req, owner, inst_addr_ok}, 3'b101);
    check("t2_fetch_addr", bus_addr, 32'hBFC0_0004);
    step();
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2402_0005;
    settle();
    check("t2_inst_data_ok", {inst_data_ok, inst_rdata}, {1'b1, 32'h2402_0005});
    step();
    bus_data_ok = 1'b0;

    // Write with slave stalling the address phase
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0100;
    data_wdata = 32'h00AB_0000; data_addr = 32'h8000_0004;
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("t3_stall_fields", {bus_req, bus_wr, bus_wstrb, bus_wdata}, {1'b1, 1'b1, 4'b0100, 32'h00AB_0000});
      check("t3_no_addr_ok", data_addr_ok, 1'b0);
    end
    step();
    bus_addr_ok = 1'b1;
    settle();
    check("t3_accept", data_addr_ok, 1'b1);
    step();
    // Stray addr_ok while in the data phase
    data_req = 1'b0;
    settle();
    check("t3_stray_addr_ok", {inst_addr_ok, data_addr_ok, busy, bus_req}, 4'b0010);
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    settle();
    check("t3_write_ack", data_data_ok, 1'b1);
    step();
    // Stray data_ok while idle
    settle();
    check("t3_stray_data_ok", {inst_data_ok, data_data_ok, busy}, 3'b000);
    step();
    bus_data_ok = 1'b0;

    // Requester drops req after grant but before addr_ok
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    step();
    inst_req = 1'b0;
    step();
    bus_addr_ok = 1'b1;
    settle();
    check("t4_late_addr_ok", {inst_addr_ok, bus_addr}, {1'b1, 32'hBFC0_0008});
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_1234;
    settle();
    check("t4_late_data_ok", {inst_data_ok, inst_rdata}, {1'b1, 32'h0000_1234});
    step();
    bus_data_ok = 1'b0;

    // Reset while in the data phase
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h8000_0020;
    step();
    bus_addr_ok = 1'b1;
    step();
    data_req = 1'b0; bus_addr_ok = 1'b0;
    settle();
    check("t5_in_data", {busy, owner}, 2'b11);
    rst = 1'b1;
    settle();
    check("t5_async_rst", {bus_req, busy, owner}, 3'b000);
    step();
    rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
    settle();
    check("t5_no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    step();
    bus_data_ok = 1'b0;

    // Grant order with both requests held continuously
`ifdef FAIR_ARB_EN
    expOrd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    expOrd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0100;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0;
    nGrants = 0;
    for (int c = 0; c < 60 && nGrants < 10; c++) begin
      step();
      settle();
      if (bus_req) begin
        gotOrd[nGrants] = owner;
        nGrants++;
      end
    end
    check("fair_grant_count", nGrants, 10);
    for (int k = 0; k < nGrants; k++) check($sformatf("fair_grant_%0d", k), gotOrd[k], expOrd[k]);

    inst_req = 1'b0; data_req = 1'b0;
    for (int c = 0; c < 10 && busy; c++) step();
    check("drain_idle", busy, 1'b0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
